// File: rtl/defines.sv
// ---------------------------------------------------------------------------
// defines: shared types and constants for the I/O timer / interrupt block.
//   scalar_t              - 32-bit I/O bus word
//   IO_TIMER_<reg>        - byte offsets of each register from BASE_ADDRESS
//   IO_TIMER_CTRL_*       - bit positions inside CTRL
//   IO_TIMER_PEND_TIMER   - PENDING / IRQ_EN bit used by the timer
// ---------------------------------------------------------------------------
package defines;

    typedef logic [31:0] scalar_t;

    localparam logic [4:0] IO_TIMER_COUNT   = 5'h00;
    localparam logic [4:0] IO_TIMER_RELOAD  = 5'h04;
    localparam logic [4:0] IO_TIMER_CTRL    = 5'h08;
    localparam logic [4:0] IO_TIMER_PENDING = 5'h0C;
    localparam logic [4:0] IO_TIMER_IRQ_EN  = 5'h10;
    localparam logic [4:0] IO_TIMER_ACK     = 5'h14;

    localparam int IO_TIMER_CTRL_ENABLE   = 0;
    localparam int IO_TIMER_CTRL_PERIODIC = 1;
    localparam int IO_TIMER_PEND_TIMER    = 0;

endpackage

// File: rtl/irq_edge_detect.sv
// ---------------------------------------------------------------------------
// irq_edge_detect: two-flop synchronizer plus rising-edge detector for a
// bank of asynchronous interrupt lines.
//   clk      - system clock
//   reset    - asynchronous active-high reset, clears all flops
//   async_in - WIDTH asynchronous input lines
//   rise     - one-cycle pulse per line on a synchronized 0->1 transition
// ---------------------------------------------------------------------------
module irq_edge_detect #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] async_in,
    output logic [WIDTH-1:0] rise
);

    logic [WIDTH-1:0] sync1;
    logic [WIDTH-1:0] sync2;
    logic [WIDTH-1:0] prev;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1 <= '0;
            sync2 <= '0;
            prev  <= '0;
        end else begin
            sync1 <= async_in;
            sync2 <= sync1;
            prev  <= sync2;
        end
    end

    // The pulse is combinational off the second sync stage; the consumer's
    // PENDING register is the third flop in the path.
    assign rise = sync2 & ~prev;

endmodule

// File: rtl/io_timer_intc.sv
// ---------------------------------------------------------------------------
// io_timer_intc: memory-mapped 32-bit down-counting timer and edge-triggered
// interrupt controller on the non-cacheable I/O bus.
//   clk, reset     - system clock, asynchronous active-high reset
//   io_write_en    - write strobe (one cycle per access)
//   io_read_en     - read strobe (one cycle per access)
//   io_address     - byte address; bits [1:0] ignored
//   io_write_data  - write data
//   io_read_data   - registered read data, valid the cycle after io_read_en
//   ext_irq        - asynchronous external interrupt sources
//   interrupt_req  - registered level interrupt, |(PENDING & IRQ_EN)
//
// Bus protocol: every access completes in the cycle its strobe is sampled;
// there is no ready/backpressure. When both strobes are high the write is
// performed and the read returns the register contents from before it.
// ---------------------------------------------------------------------------
module io_timer_intc
    import defines::*;
#(
    parameter scalar_t BASE_ADDRESS = 32'hFFFF_0100,
    parameter int      NUM_EXT_IRQ  = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   io_write_en,
    input  logic                   io_read_en,
    input  scalar_t                io_address,
    input  scalar_t                io_write_data,
    output scalar_t                io_read_data,
    input  logic [NUM_EXT_IRQ-1:0] ext_irq,
    output logic                   interrupt_req
);

    localparam int PW = NUM_EXT_IRQ + 1;

    localparam logic [2:0] W_COUNT   = IO_TIMER_COUNT[4:2];
    localparam logic [2:0] W_RELOAD  = IO_TIMER_RELOAD[4:2];
    localparam logic [2:0] W_CTRL    = IO_TIMER_CTRL[4:2];
    localparam logic [2:0] W_PENDING = IO_TIMER_PENDING[4:2];
    localparam logic [2:0] W_IRQ_EN  = IO_TIMER_IRQ_EN[4:2];
    localparam logic [2:0] W_ACK     = IO_TIMER_ACK[4:2];

    // Registers
    scalar_t       count;
    scalar_t       reload;
    logic          ctrl_enable;
    logic          ctrl_periodic;
    logic [PW-1:0] pending;
    logic [PW-1:0] irq_en;

    // Word-granular decode: subtracting the base lets any aligned base work.
    logic [29:0] word_off;
    logic [2:0]  word_idx;
    logic        hit;
    logic        unused_addr_bits;

    assign word_off         = io_address[31:2] - BASE_ADDRESS[31:2];
    assign word_idx         = word_off[2:0];
    assign hit              = (word_off[29:3] == '0) && (word_idx <= W_ACK);
    assign unused_addr_bits = ^io_address[1:0];

    logic wr_reload, wr_ctrl, wr_irq_en, wr_ack;
    assign wr_reload = io_write_en && hit && (word_idx == W_RELOAD);
    assign wr_ctrl   = io_write_en && hit && (word_idx == W_CTRL);
    assign wr_irq_en = io_write_en && hit && (word_idx == W_IRQ_EN);
    assign wr_ack    = io_write_en && hit && (word_idx == W_ACK);

    logic [NUM_EXT_IRQ-1:0] ext_rise;

    irq_edge_detect #(.WIDTH(NUM_EXT_IRQ)) u_edge (
        .clk      (clk),
        .reset    (reset),
        .async_in (ext_irq),
        .rise     (ext_rise)
    );

    // Timer and pending next-state. Bus writes are applied after the timer
    // step so a RELOAD or CTRL write overrides the timer's own update, while
    // the fire event itself depends only on the pre-write ENABLE.
    logic          timer_fire;
    scalar_t       count_next;
    logic          enable_next;
    logic          periodic_next;
    logic [PW-1:0] ack_mask;
    logic [PW-1:0] pending_next;

    always_comb begin
        timer_fire    = ctrl_enable && (count == '0);
        count_next    = count;
        enable_next   = ctrl_enable;
        periodic_next = ctrl_periodic;

        if (ctrl_enable) begin
            if (count == '0) begin
                if (ctrl_periodic) count_next  = reload;
                else               enable_next = 1'b0;
            end else begin
                count_next = count - 32'd1;
            end
        end

        if (wr_ctrl) begin
            enable_next   = io_write_data[IO_TIMER_CTRL_ENABLE];
            periodic_next = io_write_data[IO_TIMER_CTRL_PERIODIC];
        end
        if (wr_reload) count_next = io_write_data;

        // New events are ORed in after the acknowledge so a set wins.
        ack_mask     = wr_ack ? io_write_data[PW-1:0] : '0;
        pending_next = (pending & ~ack_mask) | {ext_rise, timer_fire};
    end

    // Read mux from current (pre-write) register values.
    scalar_t read_mux;

    always_comb begin
        read_mux = '0;
        if (hit) begin
            case (word_idx)
                W_COUNT:   read_mux = count;
                W_RELOAD:  read_mux = reload;
                W_CTRL: begin
                    read_mux[IO_TIMER_CTRL_ENABLE]   = ctrl_enable;
                    read_mux[IO_TIMER_CTRL_PERIODIC] = ctrl_periodic;
                end
                W_PENDING: read_mux[PW-1:0] = pending;
                W_IRQ_EN:  read_mux[PW-1:0] = irq_en;
                default:   read_mux = '0;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count         <= '0;
            reload        <= '0;
            ctrl_enable   <= 1'b0;
            ctrl_periodic <= 1'b0;
            pending       <= '0;
            irq_en        <= '0;
            io_read_data  <= '0;
            interrupt_req <= 1'b0;
        end else begin
            count         <= count_next;
            ctrl_enable   <= enable_next;
            ctrl_periodic <= periodic_next;
            pending       <= pending_next;
            if (wr_reload) reload <= io_write_data;
            if (wr_irq_en) irq_en <= io_write_data[PW-1:0];
            if (io_read_en) io_read_data <= read_mux;
            interrupt_req <= |(pending & irq_en);
        end
    end

endmodule

// File: tb/tb_io_timer_intc.sv
// ---------------------------------------------------------------------------
// tb_io_timer_intc: self-checking bench for io_timer_intc. Expected timing is
// derived from the register-level rules (fire N+1 edges after enable, three
// cycles of external-edge latency, interrupt one cycle after PENDING).
// ---------------------------------------------------------------------------
module tb_io_timer_intc;
    import defines::*;

    localparam scalar_t BASE = 32'hFFFF_0100;
    localparam int      NIRQ = 4;
    localparam int      PW   = NIRQ + 1;
    localparam scalar_t ALL  = (32'd1 << PW) - 32'd1;

    logic            clk = 1'b0;
    logic            reset;
    logic            io_write_en;
    logic            io_read_en;
    scalar_t         io_address;
    scalar_t         io_write_data;
    scalar_t         io_read_data;
    logic [NIRQ-1:0] ext_irq;
    logic            interrupt_req;

    int      checks = 0;
    int      errors = 0;
    int      cyc = 0;
    scalar_t exp_q[$];

    io_timer_intc #(.BASE_ADDRESS(BASE), .NUM_EXT_IRQ(NIRQ)) dut (
        .clk           (clk),
        .reset         (reset),
        .io_write_en   (io_write_en),
        .io_read_en    (io_read_en),
        .io_address    (io_address),
        .io_write_data (io_write_data),
        .io_read_data  (io_read_data),
        .ext_irq       (ext_irq),
        .interrupt_req (interrupt_req)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- driver tasks ----------------
    task automatic bus_write(input logic [4:0] off, input scalar_t data);
        @(negedge clk);
        io_address    = BASE + {27'd0, off};
        io_write_data = data;
        io_write_en   = 1'b1;
        @(negedge clk);
        io_write_en   = 1'b0;
    endtask

    task automatic bus_read_addr(input scalar_t addr, output scalar_t data);
        @(negedge clk);
        io_address = addr;
        io_read_en = 1'b1;
        @(negedge clk);
        io_read_en = 1'b0;
        data       = io_read_data;
    endtask

    task automatic bus_read(input logic [4:0] off, output scalar_t data);
        bus_read_addr(BASE + {27'd0, off}, data);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        scalar_t rd;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (io_read_data !== 32'd0) begin
            errors++; $display("FAIL reset_rdata: got %h expected 0", io_read_data);
        end
        checks++;
        if (interrupt_req !== 1'b0) begin
            errors++; $display("FAIL reset_irq: got %b expected 0", interrupt_req);
        end
        reset = 1'b0;

        bus_write(IO_TIMER_RELOAD, 32'd5);
        bus_write(IO_TIMER_IRQ_EN, ALL);
        bus_write(IO_TIMER_CTRL, 32'd1);
        bus_read(IO_TIMER_RELOAD, rd);
        // Asynchronous reset mid-count, away from the clock edge.
        #2 reset = 1'b1;
        #1;
        checks++;
        if (io_read_data !== 32'd0) begin
            errors++; $display("FAIL reset_async_rdata: got %h expected 0", io_read_data);
        end
        // A pulse while in reset must not be latched.
        @(negedge clk); ext_irq = 4'b1111;
        @(negedge clk); ext_irq = 4'b0000;
        @(negedge clk); reset = 1'b0;
        repeat (8) @(negedge clk);
        for (int i = 0; i < 6; i++) begin
            bus_read(5'(i * 4), rd);
            checks++;
            if (rd !== 32'd0) begin
                errors++; $display("FAIL reset_reg%0d: got %h expected 0", i, rd);
            end
        end
        checks++;
        if (interrupt_req !== 1'b0) begin
            errors++; $display("FAIL reset_irq_after: got %b expected 0", interrupt_req);
        end
    endtask

    task automatic test_decode();
        scalar_t rd, r_old, r_new;
        r_old = $urandom;
        bus_write(IO_TIMER_RELOAD, r_old);
        bus_read(IO_TIMER_RELOAD, rd);
        checks++;
        if (rd !== r_old) begin errors++; $display("FAIL dec_reload: got %h expected %h", rd, r_old); end
        bus_read(IO_TIMER_COUNT, rd);
        checks++;
        if (rd !== r_old) begin errors++; $display("FAIL dec_count_load: got %h expected %h", rd, r_old); end
        bus_read_addr(BASE + 32'h7, rd);
        checks++;
        if (rd !== r_old) begin errors++; $display("FAIL dec_misaligned: got %h expected %h", rd, r_old); end
        bus_read_addr(BASE + 32'h18, rd);
        checks++;
        if (rd !== 32'd0) begin errors++; $display("FAIL dec_out_hi: got %h expected 0", rd); end
        bus_read_addr(BASE - 32'h4, rd);
        checks++;
        if (rd !== 32'd0) begin errors++; $display("FAIL dec_out_lo: got %h expected 0", rd); end

        bus_write(IO_TIMER_IRQ_EN, 32'hFFFF_FFFF);
        bus_read(IO_TIMER_IRQ_EN, rd);
        checks++;
        if (rd !== ALL) begin errors++; $display("FAIL dec_irq_en_mask: got %h expected %h", rd, ALL); end
        bus_write(IO_TIMER_CTRL, 32'hFFFF_FFFE);
        bus_read(IO_TIMER_CTRL, rd);
        checks++;
        if (rd !== 32'd2) begin errors++; $display("FAIL dec_ctrl_mask: got %h expected 2", rd); end
        bus_write(IO_TIMER_CTRL, 32'd0);
        bus_write(IO_TIMER_ACK, 32'hFFFF_FFFF);
        bus_read(IO_TIMER_ACK, rd);
        checks++;
        if (rd !== 32'd0) begin errors++; $display("FAIL dec_ack_read: got %h expected 0", rd); end

        // Simultaneous read and write of RELOAD.
        r_new = $urandom;
        @(negedge clk);
        io_address    = BASE + 32'h4;
        io_write_data = r_new;
        io_write_en   = 1'b1;
        io_read_en    = 1'b1;
        @(negedge clk);
        io_write_en = 1'b0;
        io_read_en  = 1'b0;
        checks++;
        if (io_read_data !== r_old) begin
            errors++; $display("FAIL dec_rw_old: got %h expected %h", io_read_data, r_old);
        end
        // Out-of-range write must not land anywhere.
        @(negedge clk);
        io_address = BASE + 32'h18; io_write_data = 32'd0; io_write_en = 1'b1;
        @(negedge clk);
        io_write_en = 1'b0;
        bus_read(IO_TIMER_RELOAD, rd);
        checks++;
        if (rd !== r_new) begin errors++; $display("FAIL dec_rw_new: got %h expected %h", rd, r_new); end
        bus_read(IO_TIMER_IRQ_EN, rd);
        checks++;
        if (rd !== ALL) begin errors++; $display("FAIL dec_oob_write: got %h expected %h", rd, ALL); end
        bus_write(IO_TIMER_IRQ_EN, 32'd0);
    endtask

    task automatic test_oneshot(input int n);
        scalar_t rd;
        int t, pend_k, irq_k;
        bus_write(IO_TIMER_ACK, ALL);
        bus_write(IO_TIMER_RELOAD, scalar_t'(n));
        bus_write(IO_TIMER_IRQ_EN, 32'd1);
        bus_write(IO_TIMER_CTRL, 32'd1);
        t = cyc;
        pend_k = -1;
        irq_k  = -1;
        // Back-to-back reads of PENDING: each sample shows the value from the
        // edge before, so PENDING set at t+N+1 is seen at t+N+2.
        io_address = BASE + {27'd0, IO_TIMER_PENDING};
        io_read_en = 1'b1;
        for (int k = 1; k <= n + 8; k++) begin
            @(negedge clk);
            if (pend_k < 0 && io_read_data[0] === 1'b1) pend_k = cyc - t;
            if (irq_k < 0 && interrupt_req === 1'b1) irq_k = cyc - t;
        end
        io_read_en = 1'b0;
        checks++;
        if (pend_k !== n + 2) begin
            errors++; $display("FAIL oneshot_pend_time n=%0d: got %0d expected %0d", n, pend_k, n + 2);
        end
        checks++;
        if (irq_k !== n + 2) begin
            errors++; $display("FAIL oneshot_irq_time n=%0d: got %0d expected %0d", n, irq_k, n + 2);
        end
        bus_read(IO_TIMER_CTRL, rd);
        checks++;
        if (rd !== 32'd0) begin errors++; $display("FAIL oneshot_ctrl: got %h expected 0", rd); end
        bus_read(IO_TIMER_COUNT, rd);
        checks++;
        if (rd !== 32'd0) begin errors++; $display("FAIL oneshot_count: got %h expected 0", rd); end
        bus_read(IO_TIMER_PENDING, rd);
        checks++;
        if (rd !== 32'd1) begin errors++; $display("FAIL oneshot_pending: got %h expected 1", rd); end
        bus_write(IO_TIMER_ACK, ALL);
        bus_write(IO_TIMER_IRQ_EN, 32'd0);
    endtask

    task automatic test_periodic(input int n);
        int t, budget;
        logic prev, acking;
        scalar_t e;
        bus_write(IO_TIMER_ACK, ALL);
        bus_write(IO_TIMER_IRQ_EN, 32'd1);
        bus_write(IO_TIMER_RELOAD, scalar_t'(n));
        bus_write(IO_TIMER_CTRL, 32'd3);
        t = cyc;
        for (int p = 0; p < 4; p++) exp_q.push_back(scalar_t'(t + n + 2 + p * (n + 1)));
        prev   = 1'b0;
        acking = 1'b0;
        budget = 4 * n + 6;
        for (int k = 0; k < budget; k++) begin
            @(negedge clk);
            if (acking) begin io_write_en = 1'b0; acking = 1'b0; end
            if (interrupt_req === 1'b1 && prev === 1'b0) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++; $display("FAIL periodic_extra n=%0d: rise at %0d expected none", n, cyc);
                end else begin
                    e = exp_q.pop_front();
                    if (scalar_t'(cyc) !== e) begin
                        errors++; $display("FAIL periodic_rise n=%0d: got cycle %0d expected %0d", n, cyc, e);
                    end
                end
                io_address    = BASE + {27'd0, IO_TIMER_ACK};
                io_write_data = 32'd1;
                io_write_en   = 1'b1;
                acking        = 1'b1;
            end
            prev = interrupt_req;
        end
        @(negedge clk);
        io_write_en = 1'b0;
        checks++;
        if (exp_q.size() !== 0) begin
            errors++; $display("FAIL periodic_missing n=%0d: got %0d rises left expected 0", n, exp_q.size());
        end
        exp_q.delete();
        bus_write(IO_TIMER_CTRL, 32'd0);
        bus_write(IO_TIMER_ACK, ALL);
        bus_write(IO_TIMER_IRQ_EN, 32'd0);
    endtask

    // One-shot timer; a bus write lands on exactly the edge that fires.
    task automatic test_fire_collision(input logic [4:0] off, input scalar_t data, input int n);
        scalar_t rd;
        bus_write(IO_TIMER_ACK, ALL);
        bus_write(IO_TIMER_RELOAD, scalar_t'(n));
        bus_write(IO_TIMER_CTRL, 32'd1);
        repeat (n) @(negedge clk);
        io_address    = BASE + {27'd0, off};
        io_write_data = data;
        io_write_en   = 1'b1;
        @(negedge clk);
        io_write_en = 1'b0;
        bus_read(IO_TIMER_PENDING, rd);
        checks++;
        if (rd !== 32'd1) begin
            errors++; $display("FAIL collision_off%0h n=%0d: got %h expected 1", off, n, rd);
        end
        bus_read(IO_TIMER_CTRL, rd);
        checks++;
        if (rd !== 32'd0) begin
            errors++; $display("FAIL collision_ctrl_off%0h: got %h expected 0", off, rd);
        end
        bus_write(IO_TIMER_ACK, 32'd1);
        bus_read(IO_TIMER_PENDING, rd);
        checks++;
        if (rd !== 32'd0) begin
            errors++; $display("FAIL collision_ack_clear: got %h expected 0", rd);
        end
    endtask

    task automatic test_ext_edge();
        scalar_t rd;
        int c, irq_k;
        bus_write(IO_TIMER_ACK, ALL);
        bus_write(IO_TIMER_IRQ_EN, 32'h8);
        @(negedge clk);
        c = cyc;
        ext_irq = 4'b0100;
        irq_k = -1;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            if (k == 1) ext_irq = 4'b0000;
            if (irq_k < 0 && interrupt_req === 1'b1) irq_k = cyc - c;
        end
        checks++;
        if (irq_k !== 4) begin errors++; $display("FAIL ext_irq_time: got %0d expected 4", irq_k); end
        bus_read(IO_TIMER_PENDING, rd);
        checks++;
        if (rd !== 32'h8) begin errors++; $display("FAIL ext_pending: got %h expected 8", rd); end

        // A held level sets once; after ACK it must stay clear.
        bus_write(IO_TIMER_ACK, ALL);
        @(negedge clk); ext_irq = 4'b0100;
        repeat (6) @(negedge clk);
        bus_write(IO_TIMER_ACK, 32'h8);
        repeat (8) @(negedge clk);
        bus_read(IO_TIMER_PENDING, rd);
        checks++;
        if (rd !== 32'd0) begin errors++; $display("FAIL ext_level_retrigger: got %h expected 0", rd); end
        checks++;
        if (interrupt_req !== 1'b0) begin errors++; $display("FAIL ext_level_irq: got %b expected 0", interrupt_req); end
        ext_irq = 4'b0000;
        repeat (4) @(negedge clk);
        bus_write(IO_TIMER_ACK, ALL);
    endtask

    task automatic test_ext_random();
        scalar_t rd, mask, exp_pend, ack;
        logic [NIRQ-1:0] lines;
        logic exp_irq;
        for (int it = 0; it < 8; it++) begin
            mask  = scalar_t'($urandom_range(0, 31));
            lines = NIRQ'($urandom_range(1, 15));
            bus_write(IO_TIMER_ACK, ALL);
            bus_write(IO_TIMER_IRQ_EN, mask);
            @(negedge clk); ext_irq = lines;
            repeat ($urandom_range(1, 3)) @(negedge clk);
            ext_irq = '0;
            repeat (6) @(negedge clk);
            exp_pend = {27'd0, lines, 1'b0};
            exp_irq  = |(exp_pend & mask);
            bus_read(IO_TIMER_PENDING, rd);
            checks++;
            if (rd !== exp_pend) begin
                errors++; $display("FAIL extr_pending it=%0d: got %h expected %h", it, rd, exp_pend);
            end
            checks++;
            if (interrupt_req !== exp_irq) begin
                errors++; $display("FAIL extr_irq it=%0d: got %b expected %b", it, interrupt_req, exp_irq);
            end
            ack = scalar_t'($urandom_range(0, 31));
            bus_write(IO_TIMER_ACK, ack);
            exp_pend = exp_pend & ~ack;
            exp_irq  = |(exp_pend & mask);
            bus_read(IO_TIMER_PENDING, rd);
            checks++;
            if (rd !== exp_pend) begin
                errors++; $display("FAIL extr_ack it=%0d: got %h expected %h", it, rd, exp_pend);
            end
            checks++;
            if (interrupt_req !== exp_irq) begin
                errors++; $display("FAIL extr_ack_irq it=%0d: got %b expected %b", it, interrupt_req, exp_irq);
            end
        end
        bus_write(IO_TIMER_IRQ_EN, 32'd0);
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        reset         = 1'b1;
        io_write_en   = 1'b0;
        io_read_en    = 1'b0;
        io_address    = '0;
        io_write_data = '0;
        ext_irq       = '0;

        test_reset();
        test_decode();
        test_oneshot(3);
        test_oneshot($urandom_range(1, 12));
        test_periodic(2);
        test_periodic($urandom_range(3, 7));
        test_fire_collision(IO_TIMER_ACK, 32'd1, 2);
        test_fire_collision(IO_TIMER_ACK, 32'd1, $urandom_range(1, 8));
        test_fire_collision(IO_TIMER_CTRL, 32'd0, $urandom_range(1, 8));
        test_ext_edge();
        test_ext_random();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
